// File: rtl/gsim_mem_fetch.sv
// Row fetch sequencer between the GSIM core and the 256-bit matrix memory port.
// Define GSIM_FETCH_PERF_EN to add the o_stall_cnt request-stall counter.
module gsim_mem_fetch #(
   parameter int FIFO_DEPTH   = 4,
   parameter int ROWS_PER_MAT = 17,
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 256
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_module_en,
   input  logic [4:0]        i_matrix_num,
   output logic              o_mem_rreq,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_rrdy,
   input  logic [DATA_W-1:0] i_mem_dout,
   input  logic              i_mem_dout_vld,
   output logic              o_row_vld,
   output logic [DATA_W-1:0] o_row_data,
   output logic [4:0]        o_mat_idx,
   output logic [4:0]        o_row_idx,
   output logic              o_row_last,
   input  logic              i_row_rdy,
   output logic              o_fetch_done
`ifdef GSIM_FETCH_PERF_EN
   ,
   output logic [15:0]       o_stall_cnt
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]  DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [4:0]      LAST_ROW  = 5'(ROWS_PER_MAT - 1);
   localparam logic [ADDR_W-1:0] ROWS_C  = ADDR_W'(ROWS_PER_MAT);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} stateT;

   stateT               r_state;
   stateT               w_nextState;
   logic                r_enPrev;
   logic [4:0]          r_matNum;
   logic [ADDR_W-1:0]   r_reqCnt;
   logic                r_rreq;
   logic                r_inflight;
   logic [DATA_W-1:0]   r_fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wrPtr;
   logic [PTR_W-1:0]    r_rdPtr;
   logic [CNT_W-1:0]    r_count;
   logic [ADDR_W-1:0]   r_popCnt;
   logic [4:0]          r_matIdx;
   logic [4:0]          r_rowIdx;

   logic [ADDR_W-1:0]   w_total;
   logic                w_start;
   logic                w_active;
   logic                w_abort;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic                w_lastAccept;
   logic                w_drained;
   logic [CNT_W:0]      w_credit;

   assign w_total      = ADDR_W'(r_matNum) * ROWS_C;
   assign w_start      = (r_state == IDLE) && i_module_en && !r_enPrev;
   assign w_active     = (r_state == FETCH) || (r_state == DRAIN);
   assign w_abort      = w_active && !i_module_en;
   assign w_accept     = r_rreq && i_mem_rrdy;
   assign w_push       = w_active && i_mem_dout_vld;
   assign w_pop        = w_active && (r_count != '0) && i_row_rdy;
   assign w_lastAccept = w_accept && (r_reqCnt == w_total - ADDR_W'(1));
   assign w_drained    = (r_count == '0) && !r_inflight && (r_popCnt == w_total);
   // Occupancy after this edge plus the request about to be in flight; a pop is deliberately not credited.
   assign w_credit     = {1'b0, r_count} + (CNT_W+1)'(w_push) + (CNT_W+1)'(w_accept);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_enPrev <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_enPrev <= i_module_en;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_start) w_nextState = (i_matrix_num == 5'd0) ? DONE : FETCH;
         FETCH:   if (!i_module_en) w_nextState = IDLE;
                  else if (w_lastAccept) w_nextState = DRAIN;
         DRAIN:   if (!i_module_en) w_nextState = IDLE;
                  else if (w_drained) w_nextState = DONE;
         DONE:    if (!i_module_en) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // A pending request is held until accepted; new ones are issued only with credit left.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rreq     <= 1'b0;
         r_reqCnt   <= '0;
         r_inflight <= 1'b0;
         r_matNum   <= 5'd0;
      end else begin
         r_inflight <= w_accept && !w_abort;
         if (w_start) begin
            r_matNum <= i_matrix_num;
            r_reqCnt <= '0;
            r_rreq   <= (i_matrix_num != 5'd0);
         end else begin
            if (w_accept) r_reqCnt <= r_reqCnt + ADDR_W'(1);
            if ((r_state == FETCH) && (w_nextState == FETCH))
               r_rreq <= (r_rreq && !i_mem_rrdy) || (w_credit < DEPTH_C);
            else
               r_rreq <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || w_start || w_abort) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_fifoMem[r_wrPtr] <= i_mem_dout;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || w_start) begin
         r_popCnt <= '0;
         r_matIdx <= 5'd0;
         r_rowIdx <= 5'd0;
      end else if (w_pop) begin
         r_popCnt <= r_popCnt + ADDR_W'(1);
         if (r_rowIdx == LAST_ROW) begin
            r_rowIdx <= 5'd0;
            r_matIdx <= r_matIdx + 5'd1;
         end else begin
            r_rowIdx <= r_rowIdx + 5'd1;
         end
      end
   end

`ifdef GSIM_FETCH_PERF_EN
   logic [15:0] r_stallCnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || w_start)
         r_stallCnt <= 16'd0;
      else if (r_rreq && !i_mem_rrdy && (r_stallCnt != 16'hFFFF))
         r_stallCnt <= r_stallCnt + 16'd1;
   end

   assign o_stall_cnt = r_stallCnt;
`endif

   assign o_mem_rreq   = r_rreq;
   assign o_mem_addr   = r_reqCnt;
   assign o_row_vld    = (r_count != '0);
   assign o_row_data   = o_row_vld ? r_fifoMem[r_rdPtr] : '0;
   assign o_mat_idx    = r_matIdx;
   assign o_row_idx    = r_rowIdx;
   assign o_row_last   = (r_rowIdx == LAST_ROW);
   assign o_fetch_done = (r_state == DONE);

endmodule

// File: doc/gsim_mem_fetch.md
# gsim_mem_fetch

Read-sequencing controller between the GSIM compute core and the 256-bit matrix memory port. It walks the matrix region row by row for `i_matrix_num` matrices and issues `o_mem_rreq`/`o_mem_addr` under `i_mem_rrdy` flow control. Returned rows are buffered in a small credit-protected FIFO, so the memory return path never needs backpressure. Rows are handed to the core over a valid/ready stream tagged with matrix and row indices.

## Interface
- `FIFO_DEPTH`, 4: row buffer entries (power of two, ≥2)
- `ROWS_PER_MAT`, 17: rows per matrix (16 coefficient rows + 1 b-vector row)
- `ADDR_W`, 10: memory address width
- `DATA_W`, 256: row width (16 × 16-bit)
- `i_clk` in 1: clock, rising edge
- `i_reset` in 1: synchronous, active-high reset
- `i_module_en` in 1: level enable; its rising edge starts a job
- `i_matrix_num` in 5: matrices to fetch; sampled on the `i_module_en` rising edge
- `o_mem_rreq` out 1: read request
- `o_mem_addr` out ADDR_W: read address
- `i_mem_rrdy` in 1: memory accepts a request this cycle
- `i_mem_dout` in DATA_W: returned row
- `i_mem_dout_vld` in 1: returned row valid
- `o_row_vld` out 1: buffered row available
- `o_row_data` out DATA_W: FIFO head row
- `o_mat_idx` out 5: matrix index of the head row
- `o_row_idx` out 5: row index 0..ROWS_PER_MAT-1 of the head row
- `o_row_last` out 1: head row is the b-vector row (`o_row_idx` == ROWS_PER_MAT-1)
- `i_row_rdy` in 1: core consumes the head row
- `o_fetch_done` out 1: all rows of the job consumed

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE → FETCH on the `i_module_en` rising edge.
  - Latch `i_matrix_num`.
  - Clear the address counter, FIFO, and pop counters.
  - Total rows T = `i_matrix_num` × ROWS_PER_MAT. Maximum T is 527, which fits ADDR_W.
- If `i_matrix_num` = 0, go IDLE → DONE directly. No requests are issued.
- In FETCH, `o_mem_addr` = request counter.
- A request is accepted when `o_mem_rreq` & `i_mem_rrdy` are both high at a clock edge. The counter increments on acceptance.
- Credit rule: assert `o_mem_rreq` only when (FIFO occupancy + in-flight) < FIFO_DEPTH.
  - In-flight is 1 in the cycle after an acceptance, else 0.
  - A pop in the same cycle is not credited, which keeps the check conservative.
- Once `o_mem_rreq` is high, it and `o_mem_addr` stay stable until accepted. The exception is an `i_module_en` drop.
- FETCH → DRAIN on acceptance of request T-1.
- DRAIN → DONE when the FIFO is empty, nothing is in flight, and all T rows have been popped.
- In DONE, `o_fetch_done` = 1 and is held until `i_module_en` = 0. Then DONE → IDLE.
- Push: every `i_mem_dout_vld` writes `i_mem_dout` into the FIFO. Overflow is impossible by the credit rule.
- Pop: `o_row_vld` & `i_row_rdy`. The pop counters (`o_mat_idx`, `o_row_idx`) advance on each pop.
  - `o_row_idx` wraps from ROWS_PER_MAT-1 to 0, and `o_mat_idx` increments at the wrap.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- `i_module_en` falling in FETCH/DRAIN aborts the job:
  - Next state is IDLE.
  - The FIFO is flushed and `o_mem_rreq` = 0 in the following cycle.
  - A response arriving in the cycle after the abort is discarded.
- `i_reset` takes priority over everything. State IDLE, FIFO empty.

## Timing
- Reset values: `o_mem_rreq` 0, `o_mem_addr` 0, `o_row_vld` 0, `o_row_data` 0, `o_mat_idx` 0, `o_row_idx` 0, `o_row_last` 0, `o_fetch_done` 0.
- `o_mem_rreq` and `o_mem_addr` are registered. The first request appears in the cycle after the `i_module_en` rising edge.
- Memory latency: acceptance at edge k → `i_mem_dout_vld` during cycle k+1. Responses are in order.
- Push-to-`o_row_vld` latency: 1 cycle. The row pushed at edge k is visible after that edge.
- With `i_mem_rrdy` = 1 and `i_row_rdy` = 1 held, throughput is one row per cycle. A job takes T + 3 cycles from enable to `o_fetch_done`.
- `o_fetch_done` rises in the cycle after the last pop. It falls in the cycle after `i_module_en` = 0.

## Configuration
- `GSIM_FETCH_PERF_EN` defined:
  - Adds output `o_stall_cnt` [15:0], which counts cycles with `o_mem_rreq` & ~`i_mem_rrdy`.
  - The count clears on job start and on reset, and saturates at 0xFFFF.
- `GSIM_FETCH_PERF_EN` undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- `i_matrix_num`=1, rrdy=1, row_rdy=1:
  - Addresses 0..16 are accepted on consecutive edges.
  - 17 pops occur with `o_row_idx` 0..16, and `o_row_last` is high only at 16.
  - `o_fetch_done` rises 20 cycles after enable.
- `i_matrix_num`=0: no `o_mem_rreq`. `o_fetch_done` rises the cycle after enable and falls after `i_module_en` drops.
- `i_matrix_num`=31 with random `i_mem_rrdy`:
  - Last accepted address is 526, with no gaps or duplicates.
  - Final pop has `o_mat_idx`=30, `o_row_idx`=16.
  - Every popped row matches the memory content.
- `i_row_rdy`=0 held:
  - Exactly 4 requests are accepted, then `o_mem_rreq` stays 0.
  - Releasing `i_row_rdy` resumes fetching from address 4.
- Drop `i_module_en` after 8 accepts (in-flight response present):
  - `o_mem_rreq` = 0 next cycle and `o_row_vld` = 0.
  - The next job starts at address 0 with no stale rows.
- With `GSIM_FETCH_PERF_EN`: force `i_mem_rrdy`=0 for 5 cycles during FETCH → `o_stall_cnt`=5.
